// File: rtl/dram_pkg.sv
// rtl/dram_pkg.sv - shared command codes, FSM states and request field helpers
package dram_pkg;

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_PRE,
    ST_WAIT_RP,
    ST_ACT,
    ST_WAIT_RCD,
    ST_ISSUE,
    ST_WAIT_CCD
  } state_t;

  // Default request layout: {write, row, col}
  localparam int DEF_ROW_W = 4;
  localparam int DEF_COL_W = 3;
  localparam int DEF_REQ_W = 1 + DEF_ROW_W + DEF_COL_W;

  // Width of the shared wait-state counter; large enough for any practical tRP/tRCD/tCCD
  localparam int TMR_W = 8;

  // Bit position of the write flag for a given row/column split
  function automatic int req_wr_bit(input int row_w, input int col_w);
    return row_w + col_w;
  endfunction

  // Lowest bit of the row field
  function automatic int req_row_lsb(input int col_w);
    return col_w;
  endfunction

endpackage

// File: rtl/dram_timer.sv
// rtl/dram_timer.sv - loadable down-counter shared by the wait states
module dram_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  // Load on wait-state entry, then count down and park at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == W'(1));

endmodule

// File: rtl/dram_cmd_issuer.sv
// rtl/dram_cmd_issuer.sv - pops DRAM requests and issues PRE/ACT/RD/WR with tRP/tRCD/tCCD spacing
module dram_cmd_issuer
  import dram_pkg::*;
#(
  parameter int ROW_W = DEF_ROW_W,
  parameter int COL_W = DEF_COL_W,
  parameter int REQ_W = DEF_REQ_W,
  parameter int T_RP  = 2,
  parameter int T_RCD = 3,
  parameter int T_CCD = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [REQ_W-1:0] fifo_data,
  output logic             fifo_rd_en,
  output logic             cmd_valid,
  output logic [2:0]       cmd,
  output logic [ROW_W-1:0] cmd_addr,
  output logic             row_open,
  output logic [ROW_W-1:0] open_row,
  output logic             busy
);

  localparam int WR_BIT  = req_wr_bit(ROW_W, COL_W);
  localparam int ROW_LSB = req_row_lsb(COL_W);

  state_t state, next_state;

  logic             pop_req;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_done;

  logic             req_wr;
  logic [ROW_W-1:0] req_row;
  logic [COL_W-1:0] req_col;

  logic             fifo_wr;
  logic [ROW_W-1:0] fifo_row;
  logic [COL_W-1:0] fifo_col;

  logic             cur_wr;
  logic [ROW_W-1:0] cur_row;
  logic [COL_W-1:0] cur_col;
  logic [ROW_W-1:0] col_ext;

  assign fifo_wr  = fifo_data[WR_BIT];
  assign fifo_row = fifo_data[ROW_LSB +: ROW_W];
  assign fifo_col = fifo_data[COL_W-1:0];

  // While fetching, the request is not latched yet, so commands decoded for the
  // next state must look at the FIFO word directly
  assign cur_wr  = (state == ST_FETCH) ? fifo_wr  : req_wr;
  assign cur_row = (state == ST_FETCH) ? fifo_row : req_row;
  assign cur_col = (state == ST_FETCH) ? fifo_col : req_col;

  // Zero-extend the column into the row-wide address bus
  always_comb begin
    col_ext = '0;
    col_ext[COL_W-1:0] = cur_col;
  end

  dram_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic, pop request and wait-timer loading
  always_comb begin
    next_state = state;
    pop_req    = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop_req    = 1'b1;
          next_state = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (row_open && (fifo_row == open_row)) begin
          next_state = ST_ISSUE;
        end else if (row_open) begin
          next_state = ST_PRE;
        end else begin
          next_state = ST_ACT;
        end
      end
      ST_PRE: begin
        if (T_RP == 1) begin
          next_state = ST_ACT;
        end else begin
          next_state = ST_WAIT_RP;
          tmr_load   = 1'b1;
          tmr_val    = TMR_W'(T_RP - 1);
        end
      end
      ST_WAIT_RP: begin
        if (tmr_done) next_state = ST_ACT;
      end
      ST_ACT: begin
        if (T_RCD == 1) begin
          next_state = ST_ISSUE;
        end else begin
          next_state = ST_WAIT_RCD;
          tmr_load   = 1'b1;
          tmr_val    = TMR_W'(T_RCD - 1);
        end
      end
      ST_WAIT_RCD: begin
        if (tmr_done) next_state = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (T_CCD == 1) begin
          next_state = ST_IDLE;
        end else begin
          next_state = ST_WAIT_CCD;
          tmr_load   = 1'b1;
          tmr_val    = TMR_W'(T_CCD - 1);
        end
      end
      ST_WAIT_CCD: begin
        if (tmr_done) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Reset must silence the pop strobe immediately even though IDLE is the reset state
  assign fifo_rd_en = pop_req & ~rst;
  assign busy       = (state != ST_IDLE);

  // Latch the popped request while in FETCH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_wr  <= 1'b0;
      req_row <= '0;
      req_col <= '0;
    end else if (state == ST_FETCH) begin
      req_wr  <= fifo_wr;
      req_row <= fifo_row;
      req_col <= fifo_col;
    end
  end

  // Registered Moore command outputs and open-row tracking, decoded from the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_valid <= 1'b0;
      cmd       <= CMD_NOP;
      cmd_addr  <= '0;
      row_open  <= 1'b0;
      open_row  <= '0;
    end else begin
      cmd_valid <= 1'b0;
      cmd       <= CMD_NOP;
      cmd_addr  <= '0;
      case (next_state)
        ST_PRE: begin
          cmd_valid <= 1'b1;
          cmd       <= CMD_PRE;
          row_open  <= 1'b0;
          open_row  <= '0;
        end
        ST_ACT: begin
          cmd_valid <= 1'b1;
          cmd       <= CMD_ACT;
          cmd_addr  <= cur_row;
          row_open  <= 1'b1;
          open_row  <= cur_row;
        end
        ST_ISSUE: begin
          cmd_valid <= 1'b1;
          cmd       <= cur_wr ? CMD_WR : CMD_RD;
          cmd_addr  <= col_ext;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dram_cmd_issuer.sv
// tb/tb_dram_cmd_issuer.sv - self-checking bench for dram_cmd_issuer
module tb_dram_cmd_issuer;

  localparam int T_RP  = 2;
  localparam int T_RCD = 3;
  localparam int T_CCD = 2;

  logic       clk;
  logic       rst;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd_en;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic [3:0] cmd_addr;
  logic       row_open;
  logic [3:0] open_row;
  logic       busy;

  dram_cmd_issuer dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .cmd_valid  (cmd_valid),
    .cmd        (cmd),
    .cmd_addr   (cmd_addr),
    .row_open   (row_open),
    .open_row   (open_row),
    .busy       (busy)
  );

  int n_tot  = 0;
  int n_pass = 0;

  logic [7:0] q[$];

  // model state
  int cyc       = 0;
  int idle_at   = 0;
  int busy_from = 0;
  int m_open    = 0;
  int m_row     = 0;
  int exp_cmd[int];
  int exp_addr[int];
  int ev_open[int];
  int ev_row[int];

  // observation buffers for literal scenario checks
  logic       ov[16];
  logic [2:0] oc[16];
  logic [3:0] oa[16];
  logic       ore[16];
  logic       oro[16];
  logic [3:0] oor[16];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic int pk(input logic v, input logic [2:0] c, input logic [3:0] a);
    return int'(v) * 256 + int'(c) * 16 + int'(a);
  endfunction

  task automatic push(input logic [7:0] w);
    q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic observe(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      ov[i]  = cmd_valid;
      oc[i]  = cmd;
      oa[i]  = cmd_addr;
      ore[i] = fifo_rd_en;
      oro[i] = row_open;
      oor[i] = open_row;
    end
  endtask

  // FIFO: registered read data appears the cycle after the pop strobe
  always begin
    logic p;
    @(negedge clk);
    p = fifo_rd_en;
    @(posedge clk);
    #1;
    if (p && q.size() != 0) begin
      fifo_data  = q.pop_front();
      fifo_empty = (q.size() == 0);
    end
  end

  // Reference model and per-cycle compare
  always @(negedge clk) begin
    int t;
    int e_valid, e_cmd, e_addr, e_pop, e_busy;
    logic [7:0] w;
    int wr, row, col;
    if (rst) begin
      exp_cmd.delete();
      exp_addr.delete();
      ev_open.delete();
      ev_row.delete();
      m_open    = 0;
      m_row     = 0;
      idle_at   = cyc + 1;
      busy_from = cyc + 1;
      chk("rst_valid", cmd_valid, 0);
      chk("rst_cmd", cmd, 0);
      chk("rst_addr", cmd_addr, 0);
      chk("rst_rowstate", {row_open, open_row}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_pop", fifo_rd_en, 0);
    end else begin
      if (ev_open.exists(cyc)) begin
        m_open = ev_open[cyc];
        m_row  = ev_row[cyc];
      end
      e_pop = (cyc >= idle_at && !fifo_empty) ? 1 : 0;
      if (e_pop != 0) begin
        w   = (q.size() != 0) ? q[0] : 8'h00;
        wr  = int'(w[7]);
        row = int'(w[6:3]);
        col = int'(w[2:0]);
        t   = cyc + 2;
        if (!(m_open != 0 && m_row == row)) begin
          if (m_open != 0) begin
            exp_cmd[t] = 4; exp_addr[t] = 0;
            ev_open[t] = 0; ev_row[t] = 0;
            t = t + T_RP;
          end
          exp_cmd[t] = 1; exp_addr[t] = row;
          ev_open[t] = 1; ev_row[t] = row;
          t = t + T_RCD;
        end
        exp_cmd[t]  = (wr != 0) ? 3 : 2;
        exp_addr[t] = col;
        busy_from   = cyc + 1;
        idle_at     = t + T_CCD;
      end
      if (exp_cmd.exists(cyc)) begin
        e_valid = 1; e_cmd = exp_cmd[cyc]; e_addr = exp_addr[cyc];
      end else begin
        e_valid = 0; e_cmd = 0; e_addr = 0;
      end
      e_busy = (cyc >= busy_from && cyc < idle_at) ? 1 : 0;
      chk("pop", fifo_rd_en, e_pop);
      chk("cmd_valid", cmd_valid, e_valid);
      chk("cmd", cmd, e_cmd);
      chk("cmd_addr", cmd_addr, e_addr);
      chk("row_open", row_open, m_open);
      chk("open_row", open_row, m_row);
      chk("busy", busy, e_busy);
    end
    cyc++;
  end

  initial begin
    int nc;
    rst        = 1'b1;
    fifo_empty = 1'b1;
    fifo_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // closed-row read 0x2B: row 5 col 3
    @(posedge clk); #2; push(8'h2B);
    observe(8);
    chk("cr_pop", ore[0], 1);
    chk("cr_act", pk(ov[2], oc[2], oa[2]), pk(1'b1, 3'd1, 4'd5));
    chk("cr_rd", pk(ov[5], oc[5], oa[5]), pk(1'b1, 3'd2, 4'd3));
    chk("cr_open", {oro[7], oor[7]}, 5'h15);

    // row-hit write 0xAE: row 5 col 6
    @(posedge clk); #2; push(8'hAE);
    observe(5);
    chk("hit_wr", pk(ov[2], oc[2], oa[2]), pk(1'b1, 3'd3, 4'd6));
    nc = 0;
    for (int i = 0; i < 5; i++) nc += int'(ov[i]);
    chk("hit_ncmd", nc, 1);

    // row-miss read 0x4A: row 9 col 2
    @(posedge clk); #2; push(8'h4A);
    observe(10);
    chk("miss_pre", pk(ov[2], oc[2], oa[2]), pk(1'b1, 3'd4, 4'd0));
    chk("miss_act", pk(ov[4], oc[4], oa[4]), pk(1'b1, 3'd1, 4'd9));
    chk("miss_rd", pk(ov[7], oc[7], oa[7]), pk(1'b1, 3'd2, 4'd2));
    chk("miss_open", {oro[9], oor[9]}, 5'h19);

    // back-to-back hits on row 9
    @(posedge clk); #2; push(8'h49); push(8'hCD);
    observe(9);
    chk("b2b_first", pk(ov[2], oc[2], oa[2]), pk(1'b1, 3'd2, 4'd1));
    chk("b2b_pop2", ore[4], 1);
    chk("b2b_second", pk(ov[6], oc[6], oa[6]), pk(1'b1, 3'd3, 4'd5));

    // reset during WAIT_RCD, then closed-row read again
    @(posedge clk); #2; push(8'h2B);
    observe(6);
    chk("wr_pre_open", oro[5], 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", cmd_valid, 0);
    chk("ar_cmd", cmd, 0);
    chk("ar_row_open", row_open, 0);
    chk("ar_open_row", open_row, 0);
    chk("ar_busy", busy, 0);
    chk("ar_pop", fifo_rd_en, 0);
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #2; push(8'h2B);
    observe(8);
    chk("rr_act", pk(ov[2], oc[2], oa[2]), pk(1'b1, 3'd1, 4'd5));
    chk("rr_rd", pk(ov[5], oc[5], oa[5]), pk(1'b1, 3'd2, 4'd3));

    // randomized traffic with occasional resets
    for (int i = 0; i < 300; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        @(negedge clk); #2 rst = 1'b1;
        @(posedge clk); @(posedge clk);
        #1 rst = 1'b0;
      end else if (r < 75) begin
        @(posedge clk); #2;
        push({1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 3'($urandom_range(0, 7))});
      end
      repeat ($urandom_range(0, 6)) @(posedge clk);
    end

    for (int i = 0; i < 4000 && q.size() != 0; i++) @(posedge clk);
    chk("drain", q.size(), 0);
    repeat (30) @(posedge clk);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/dram_cmd_issuer.md
# dram_cmd_issuer

Read-side consumer of the DRAM request FIFO. Pops one request word at a time from `fifo_dram`, decodes write flag, row and column, and drives single-bank DRAM commands (PRE/ACT/RD/WR) under an open-row policy while enforcing tRP, tRCD and tCCD spacing. Sits between the request FIFO and the DRAM PHY command port.

## Interface
Parameters:
- `ROW_W`, 4: row address width.
- `COL_W`, 3: column address width; must satisfy `COL_W <= ROW_W`.
- `REQ_W`, 8: request word width; must equal `1+ROW_W+COL_W`.
- `T_RP`, 2: cycles from PRE issue to ACT issue; must be ≥1.
- `T_RCD`, 3: cycles from ACT issue to RD/WR issue; must be ≥1.
- `T_CCD`, 2: cycles from RD/WR issue to the earliest next pop; must be ≥1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_data` in REQ_W: FIFO registered read data, valid the cycle after `fifo_rd_en`.
- `fifo_rd_en` out 1: one-cycle pop strobe.
- `cmd_valid` out 1: a command is present this cycle.
- `cmd` out 3: command code (NOP/ACT/RD/WR/PRE).
- `cmd_addr` out ROW_W: row for ACT, zero-extended column for RD/WR, 0 for PRE/NOP.
- `row_open` out 1: a row is currently open.
- `open_row` out ROW_W: the open row; 0 when none is open.
- `busy` out 1: FSM not in IDLE.

## Operation
- Request word: bit `REQ_W-1` = write; bits `[ROW_W+COL_W-1:COL_W]` = row; `[COL_W-1:0]` = column.
- FSM states: IDLE, FETCH, PRE, WAIT_RP, ACT, WAIT_RCD, ISSUE, WAIT_CCD.
- IDLE: if `!fifo_empty`, assert `fifo_rd_en` and go to FETCH. Otherwise stay in IDLE.
- FETCH: latch `fifo_data`, then branch:
  - row hit (`row_open` and rows equal) → ISSUE;
  - row open but rows differ → PRE;
  - no row open → ACT.
- PRE: clear `row_open` and `open_row`. Go to WAIT_RP, or go directly to ACT if `T_RP==1`.
- ACT: set `row_open`, load `open_row`. Go to WAIT_RCD, or go directly to ISSUE if `T_RCD==1`.
- ISSUE: drive RD or WR with the latched column. Go to WAIT_CCD, or go directly to IDLE if `T_CCD==1`.
- Wait states: a down-counter is loaded with `param-1` on entry. The FSM leaves the wait state when the counter reaches 1.
- Rows stay open after RD/WR. Nothing closes a row except a row miss or reset.
- `fifo_rd_en` is never asserted while `fifo_empty` is high, and never outside IDLE.
- `cmd`, `cmd_addr` and `cmd_valid` are registered, Moore-decoded from the state. `cmd_valid` is high for exactly one cycle per PRE/ACT/RD/WR; `cmd` is NOP otherwise.

## Timing
- Reset (asynchronous, takes effect immediately): state IDLE, counter 0; all outputs 0; `cmd`=NOP.
- Reset asserted mid-sequence:
  - the in-flight request is discarded;
  - the row is treated as closed;
  - the next request starts with ACT.
- Pop at cycle c0 → FETCH at c1. First command lands as follows:
  - row hit: RD/WR at c2;
  - closed row: ACT at c2, RD/WR at c2+T_RCD;
  - row miss: PRE at c2, ACT at c2+T_RP, RD/WR at c2+T_RP+T_RCD.
- RD/WR at cycle n → IDLE at n+T_CCD; a pop is permitted in that cycle.
- The FIFO empty flag is sampled only in IDLE; it has settled by then because IDLE is at least 2 cycles after the previous pop.

## Structure
- Shared package `dram_pkg` holds:
  - command-code constants: NOP=0, ACT=1, RD=2, WR=3, PRE=4;
  - the FSM state typedef;
  - the request field-extraction localparams.
- One natural sub-module: `dram_timer`, a loadable down-counter with a `done` output. It is shared by the three wait states, since only one wait is ever active at a time.

## Test plan
All values use the default parameters.
- **Reset:** assert `rst` mid-cycle → all outputs 0 immediately, `cmd`=NOP, `busy`=0.
- **Closed-row read:** FIFO holds 0x2B (read, row 5, col 3) → `fifo_rd_en` at c0, ACT addr 5 at c2, RD addr 3 at c5; afterwards `row_open`=1, `open_row`=5.
- **Row-hit write:** after the above, FIFO holds 0xAE (write, row 5, col 6) → pop c0, WR addr 6 at c2, no PRE/ACT.
- **Row-miss read:** then 0x4A (read, row 9, col 2) → PRE at c2, ACT addr 9 at c4, RD addr 2 at c7; `open_row`=9.
- **Back-to-back hits:** two hits queued → first RD/WR at c2, second pop at c4, second RD/WR at c6; `fifo_rd_en` never high while `fifo_empty`=1.
- **Reset during WAIT_RCD:** outputs clear and `row_open`=0; then 0x2B → ACT at c2, RD at c5.
